// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg
// Shared definitions for the WS2812B transmitter/receiver pair: receiver
// state encoding, default line timing in clk cycles, and the bit positions
// of the G/R/B fields inside a 24-bit pixel word (MSB is sent first).
package ws2812b_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } rx_state_e;

  // Default timing, in clk cycles, shared with the transmitter.
  localparam int T0H   = 20;
  localparam int T1H   = 40;
  localparam int T_BIT = 62;
  localparam int RESET = 2500;

  // GRB field offsets within the 24-bit pixel word.
  localparam int G_MSB = 23;
  localparam int G_LSB = 16;
  localparam int R_MSB = 15;
  localparam int R_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

endpackage

// File: rtl/ws2812b_rx_sync_2ff.sv
// sync_2ff
// One-bit two-flop synchronizer for bringing an asynchronous level into the
// clk domain. Both flops reset to 0.
//   clk    : destination clock
//   nreset : asynchronous active-low reset
//   d      : asynchronous input
//   q      : synchronized output (2 clk cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ws2812b_rx.sv
// ws2812b_rx
// WS2812B serial-stream decoder. Measures high-pulse widths on the
// synchronized line, assembles 24-bit GRB pixels MSB first and presents each
// one with its position in the chain. A long low gap ends the frame.
//   clk         : system clock
//   nreset      : asynchronous active-low reset
//   din         : serial line, asynchronous to clk
//   address     : index of the presented pixel
//   r, g, b     : decoded colour of the presented pixel
//   pixel_valid : one-cycle strobe, address/r/g/b valid
//   frame_done  : one-cycle strobe on the latch gap
//   error       : one-cycle strobe on any protocol violation
//
// state | meaning
// SYNC  | waiting for a full latch gap before trusting the line
// IDLE  | line low between frames
// HIGH  | measuring a high pulse
// LOW   | measuring the low time after a bit
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int CNT_BITS     = 12,
  parameter int COUNT_BITS   = 8,
  parameter int MAX_ADDRESS  = 255,
  parameter int MIN_HIGH     = 8,
  parameter int THRESHOLD    = 30,
  parameter int MAX_HIGH     = 60,
  parameter int RESET_CYCLES = RESET
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  din,
  output logic [COUNT_BITS-1:0] address,
  output logic [7:0]            r,
  output logic [7:0]            g,
  output logic [7:0]            b,
  output logic                  pixel_valid,
  output logic                  frame_done,
  output logic                  error
);

  // One extra bit so the pixel index can sit at MAX_ADDRESS+1 once the
  // chain is full.
  localparam int IDX_BITS = COUNT_BITS + 1;

  localparam logic [CNT_BITS-1:0] MIN_HIGH_C  = CNT_BITS'(MIN_HIGH);
  localparam logic [CNT_BITS-1:0] THRESH_C    = CNT_BITS'(THRESHOLD);
  localparam logic [CNT_BITS-1:0] MAX_HIGH_C  = CNT_BITS'(MAX_HIGH);
  localparam logic [CNT_BITS-1:0] RESET_C     = CNT_BITS'(RESET_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_ONE     = CNT_BITS'(1);
  localparam logic [IDX_BITS-1:0] MAX_ADDR_C  = IDX_BITS'(MAX_ADDRESS);
  localparam logic [IDX_BITS-1:0] IDX_ONE     = IDX_BITS'(1);

  logic                din_s;
  rx_state_e           state;
  logic [CNT_BITS-1:0] high_cnt;
  logic [CNT_BITS-1:0] low_cnt;
  logic [4:0]          bit_cnt;
  logic [22:0]         shift_reg;
  logic [IDX_BITS-1:0] pix_idx;

  logic [CNT_BITS-1:0] high_inc;
  logic [CNT_BITS-1:0] low_inc;
  logic                bit_in;
  logic [23:0]         pixel_word;

  sync_2ff u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (din),
    .q      (din_s)
  );

  assign high_inc   = high_cnt + CNT_ONE;
  assign low_inc    = low_cnt + CNT_ONE;
  assign bit_in     = (high_cnt > THRESH_C);
  // Only 23 earlier bits are kept; the 24th arrives on the falling edge
  // that completes the pixel.
  assign pixel_word = {shift_reg, bit_in};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= SYNC;
      high_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      pix_idx     <= '0;
      address     <= '0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;

      case (state)
        SYNC: begin
          if (din_s) begin
            low_cnt <= '0;
          end else if (low_inc == RESET_C) begin
            state   <= IDLE;
            low_cnt <= '0;
            bit_cnt <= '0;
            pix_idx <= '0;
          end else begin
            low_cnt <= low_inc;
          end
        end

        IDLE: begin
          // The first high cycle is counted here so that high_cnt equals
          // the pulse width when the falling edge is seen.
          if (din_s) begin
            state    <= HIGH;
            high_cnt <= CNT_ONE;
          end
        end

        HIGH: begin
          if (din_s) begin
            if (high_inc == MAX_HIGH_C) begin
              error   <= 1'b1;
              state   <= SYNC;
              low_cnt <= '0;
              bit_cnt <= '0;
            end else begin
              high_cnt <= high_inc;
            end
          end else if (high_cnt < MIN_HIGH_C) begin
            error   <= 1'b1;
            state   <= SYNC;
            low_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            state     <= LOW;
            low_cnt   <= CNT_ONE;
            shift_reg <= pixel_word[22:0];
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (pix_idx <= MAX_ADDR_C) begin
                address     <= pix_idx[COUNT_BITS-1:0];
                g           <= pixel_word[G_MSB:G_LSB];
                r           <= pixel_word[R_MSB:R_LSB];
                b           <= pixel_word[B_MSB:B_LSB];
                pixel_valid <= 1'b1;
                pix_idx     <= pix_idx + IDX_ONE;
              end else begin
                // Chain full: drop the pixel, index stays at MAX_ADDRESS+1.
                error <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end

        LOW: begin
          if (din_s) begin
            state    <= HIGH;
            high_cnt <= CNT_ONE;
          end else if (low_inc == RESET_C) begin
            state      <= IDLE;
            low_cnt    <= '0;
            frame_done <= 1'b1;
            error      <= (bit_cnt != 5'd0);
            bit_cnt    <= '0;
            pix_idx    <= '0;
          end else begin
            low_cnt <= low_inc;
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_rx.sv
// tb_ws2812b_rx
// Scoreboard bench for ws2812b_rx (MAX_ADDRESS=1). Stimulus tasks drive the
// serial line and push the expected output events (with the expected cycle
// where it is fixed by the line timing); a negedge monitor pops and compares
// every pixel_valid / frame_done / error strobe.
module tb_ws2812b_rx;
  import ws2812b_pkg::*;

  localparam int MAXA = 1;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       din = 1'b0;
  logic [7:0] address;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       pixel_valid;
  logic       frame_done;
  logic       error;

  ws2812b_rx #(.MAX_ADDRESS(MAXA)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .din         (din),
    .address     (address),
    .r           (r),
    .g           (g),
    .b           (b),
    .pixel_valid (pixel_valid),
    .frame_done  (frame_done),
    .error       (error)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    bit         pv;
    bit         fd;
    bit         er;
    logic [7:0] addr;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    longint     exp_cyc;
  } ev_t;

  ev_t    sb[$];
  int     total = 0;
  int     bad = 0;
  longint last_fall = 0;

  function automatic logic [23:0] grb(input logic [7:0] rr, input logic [7:0] gg,
                                      input logic [7:0] bb);
    return {gg, rr, bb};
  endfunction

  task automatic push(input string nm, input bit pv, input bit fd, input bit er,
                      input logic [7:0] a, input logic [23:0] w, input longint at);
    ev_t e;
    e.name    = nm;
    e.pv      = pv;
    e.fd      = fd;
    e.er      = er;
    e.addr    = a;
    e.g       = w[23:16];
    e.r       = w[15:8];
    e.b       = w[7:0];
    e.exp_cyc = at;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 = no event expected, 1 = pixel at addr, 2 = error on last bit.
  // tmode encodes ones as 31-cycle and zeros as alternating 30/8-cycle pulses.
  task automatic send_word(input logic [23:0] w, input int nbits, input bit tmode,
                           input string nm, input int kind, input logic [7:0] addr);
    for (int i = 0; i < nbits; i++) begin
      logic v;
      int   hw;
      v  = w[23-i];
      hw = v ? T1H : T0H;
      if (tmode) hw = v ? 31 : (((i % 2) == 1) ? 8 : 30);
      din = 1'b1;
      tick(hw);
      din = 1'b0;
      last_fall = cyc;
      if (i == nbits - 1) begin
        if (kind == 1) push(nm, 1'b1, 1'b0, 1'b0, addr, w, last_fall + 3);
        else if (kind == 2) push(nm, 1'b0, 1'b0, 1'b1, 8'd0, 24'd0, last_fall + 3);
      end
      tick(v ? 22 : 42);
    end
  endtask

  task automatic gap(input string nm, input bit fd, input bit er);
    if (fd) push(nm, 1'b0, 1'b1, er, 8'd0, 24'd0, last_fall + 2502);
    din = 1'b0;
    tick(2600);
  endtask

  task automatic check_reset(input string nm);
    total++;
    if ({address, r, g, b, pixel_valid, frame_done, error} !== 35'd0) begin
      bad++;
      $display("FAIL %s: got addr=%0d r=%h g=%h b=%h pv=%0b fd=%0b er=%0b, required all zero",
               nm, address, r, g, b, pixel_valid, frame_done, error);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (nreset && (pixel_valid || frame_done || error)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got pv=%0b fd=%0b er=%0b addr=%0d at cycle %0d, required no event",
                 pixel_valid, frame_done, error, address, cyc);
      end else begin
        e = sb.pop_front();
        if ({pixel_valid, frame_done, error} !== {e.pv, e.fd, e.er} ||
            (e.pv && ({address, r, g, b} !== {e.addr, e.r, e.g, e.b}))) begin
          bad++;
          $display("FAIL %s: got pv=%0b fd=%0b er=%0b addr=%0d r=%h g=%h b=%h, required pv=%0b fd=%0b er=%0b addr=%0d r=%h g=%h b=%h",
                   e.name, pixel_valid, frame_done, error, address, r, g, b,
                   e.pv, e.fd, e.er, e.addr, e.r, e.g, e.b);
        end
        if (e.exp_cyc >= 0) begin
          total++;
          if (cyc != e.exp_cyc) begin
            bad++;
            $display("FAIL %s_cycle: got cycle %0d, required %0d", e.name, cyc, e.exp_cyc);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    nreset = 1'b0;
    din    = 1'b0;
    tick(3);
    @(negedge clk);
    check_reset("reset_init");
    nreset = 1'b1;
    tick(1);
    tick(2600);

    // Two-pixel frame.
    send_word(grb(8'h11, 8'h22, 8'h33), 24, 1'b0, "pix_a0", 1, 8'd0);
    send_word(grb(8'h44, 8'h55, 8'h66), 24, 1'b0, "pix_a1", 1, 8'd1);
    gap("fd_a", 1'b1, 1'b0);

    // Threshold (30 -> 0, 31 -> 1) and minimum-width (8) pulses.
    send_word(grb(8'h3C, 8'hA5, 8'h0F), 24, 1'b1, "pix_thr", 1, 8'd0);
    gap("fd_thr", 1'b1, 1'b0);

    // 7-cycle pulse after 5 good bits: error, back to SYNC, no frame_done.
    send_word(grb(8'hFF, 8'hFF, 8'hFF), 5, 1'b0, "", 0, 8'd0);
    din = 1'b1;
    tick(7);
    din = 1'b0;
    last_fall = cyc;
    push("err_short", 1'b0, 1'b0, 1'b1, 8'd0, 24'd0, last_fall + 3);
    tick(40);
    tick(2600);

    // Stuck high: error when the count reaches 60; following pixel ignored.
    din = 1'b1;
    push("err_stuck", 1'b0, 1'b0, 1'b1, 8'd0, 24'd0, cyc + 62);
    tick(80);
    din = 1'b0;
    tick(50);
    send_word(grb(8'h12, 8'h34, 8'h56), 24, 1'b0, "", 0, 8'd0);
    tick(2600);

    // Partial pixel: frame_done and error together, then address restarts.
    send_word(grb(8'hC3, 8'h81, 8'h7E), 12, 1'b0, "", 0, 8'd0);
    gap("fd_err_partial", 1'b1, 1'b1);
    send_word(grb(8'h01, 8'h80, 8'hFE), 24, 1'b0, "pix_after_partial", 1, 8'd0);
    gap("fd_p", 1'b1, 1'b0);

    // Overflow with MAX_ADDRESS=1.
    send_word(grb(8'hA1, 8'hB2, 8'hC3), 24, 1'b0, "pix_ov0", 1, 8'd0);
    send_word(grb(8'hD4, 8'hE5, 8'hF6), 24, 1'b0, "pix_ov1", 1, 8'd1);
    send_word(grb(8'h99, 8'h88, 8'h77), 24, 1'b0, "err_ov", 2, 8'd0);
    gap("fd_ov", 1'b1, 1'b0);

    // Reset after 10 bits, frame right after release ignored, then normal.
    send_word(grb(8'h5A, 8'hA5, 8'h3C), 10, 1'b0, "", 0, 8'd0);
    nreset = 1'b0;
    tick(4);
    @(negedge clk);
    check_reset("reset_mid");
    nreset = 1'b1;
    tick(1);
    send_word(grb(8'h77, 8'h66, 8'h55), 24, 1'b0, "", 0, 8'd0);
    tick(2600);
    send_word(grb(8'h0A, 8'h0B, 8'h0C), 24, 1'b0, "pix_after_reset", 1, 8'd0);
    gap("fd_r", 1'b1, 1'b0);

    tick(20);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_events: got %0d events never seen, required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
